pe_stream_driver: RTL and testbench
===================================

# pe_stream_driver

Upstream/downstream driver for one PE wrapper. It streams a programmed number of ifmap, filter and ipsum words from valid/ready sources into the PE's push/full FIFO ports, and drains a programmed number of opsum words from the PE's pop/empty port into a valid/ready sink. It raises `done` when every stream has completed. It sits between the global buffer and a PE instance and is the transmitter and receiver counterpart of the PE FIFO interface.

## Interface
Parameters:
- `DATA_WIDTH_IFMAP`, 16, ifmap word width (matches PE ifmap FIFO write width)
- `DATA_WIDTH_FILTER`, 64, filter word width
- `DATA_WIDTH_PSUM`, 64, ipsum/opsum word width
- `COUNT_WIDTH`, 16, width of per-stream word counters

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `configure`  in  1  latch the four counts (honoured in IDLE only)
- `ifmap_count`, `filter_count`, `ipsum_count`, `opsum_count`  in  COUNT_WIDTH each  words per stream for the next run
- `start`  in  1  begin run (IDLE only)
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse at run completion
- `src_ifmap_data`  in  DATA_WIDTH_IFMAP; `src_ifmap_valid`  in  1; `src_ifmap_ready`  out  1
- `src_filter_data`  in  DATA_WIDTH_FILTER; `src_filter_valid`  in  1; `src_filter_ready`  out  1
- `src_ipsum_data`  in  DATA_WIDTH_PSUM; `src_ipsum_valid`  in  1; `src_ipsum_ready`  out  1
- `ifmap`  out  DATA_WIDTH_IFMAP; `push_ifmap`  out  1; `ifmap_fifo_full`  in  1
- `filter`  out  DATA_WIDTH_FILTER; `push_filter`  out  1; `filter_fifo_full`  in  1
- `ipsum`  out  DATA_WIDTH_PSUM; `push_ipsum`  out  1; `ipsum_fifo_full`  in  1
- `opsum`  in  DATA_WIDTH_PSUM; `pop_opsum`  out  1; `opsum_fifo_empty`  in  1
- `dst_opsum_data`  out  DATA_WIDTH_PSUM; `dst_opsum_valid`  out  1; `dst_opsum_ready`  in  1

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on `configure`, load the four remaining counters from the count inputs. `configure` is ignored outside IDLE.
- IDLE with `start`: go to RUN. If all four counters are zero, go to DONE instead.
- Feed channel x (ifmap/filter/ipsum):
  - `src_x_ready = RUN & ~x_fifo_full & rem_x != 0`
  - `push_x = src_x_ready & src_x_valid`
  - `x = src_x_data`, passed through combinationally
  - each push decrements `rem_x`
  - channels are independent; all three may push in the same cycle.
- Drain:
  - `pop_opsum = RUN & ~opsum_fifo_empty & rem_opsum != 0 & ~pend & (~dst_opsum_valid | dst_opsum_ready)`
  - `pend` is set the cycle after a pop. In that cycle `opsum` is captured into the output register, `dst_opsum_valid` is set and `rem_opsum` is decremented.
  - `dst_opsum_valid` is held until `dst_opsum_ready`. Data is stable while valid and not ready.
  - at most one pop is in flight, so peak drain rate is one word per 2 cycles.
- RUN to DONE when all four counters are zero, `pend` = 0, and the output register is empty or being accepted this cycle.
- DONE: `done` = 1 for exactly one cycle, then IDLE. Counters are not reloaded; a second `start` without `configure` completes immediately.
- Counter arithmetic is unsigned COUNT_WIDTH. A counter never decrements below zero, because push/pop are gated by `rem != 0`.

## Timing
- Reset (synchronous): state = IDLE, all counters = 0, `pend` = 0. Every output is 0: `busy`, `done`, all push/pop/ready, `dst_opsum_valid`, `dst_opsum_data`. Pass-through data outputs follow their sources.
- `busy` rises the cycle after `start` is sampled.
- `done` is asserted the cycle after the last completion condition is met.
- Feed latency: 0 cycles, combinational from `src_x_valid` to `push_x`.
- Drain latency: `pop_opsum` to `dst_opsum_valid` is 2 cycles (the PE FIFO has a registered read; data is valid the cycle after pop).
- Full asserted during a cycle: no push that cycle and no word is lost. The source keeps valid and data.
- `reset` mid-run: immediate return to IDLE. An in-flight opsum word is discarded.

## Configuration
- `PE_DRIVER_ABORT_EN` defined: adds input port `abort` (1 bit).
  - `abort` in RUN: next cycle is IDLE with all counters cleared and `dst_opsum_valid` cleared.
  - a pending popped word is discarded.
  - no `done` pulse.
  - `abort` outside RUN has no effect.
- Macro not defined: no `abort` port. A run can end only by completion or `reset`.

## Structure
- Package `pe_driver_pkg`:
  - state enum `{IDLE, RUN, DONE}`
  - default width localparams (16/64/64/16)
- Sub-module `pe_feed_channel` (parameter WIDTH): counter load/decrement plus ready/push gating. Instantiated three times.
- Drain logic and FSM live in the top module.

## Test plan
1. Counts ifmap=4, filter=2, ipsum=3, opsum=3. Sources always valid, full=0, empty=0, sink always ready.
   - Exactly 4/2/3 pushes.
   - 3 opsum words out at 2-cycle spacing, in FIFO order.
   - `done` pulses once; `busy` is high from the cycle after `start` until `done`.
2. Ifmap count=5 with `ifmap_fifo_full` held high for cycles 2–4 of the run.
   - No `push_ifmap` in those cycles; 5 pushes in total.
   - Data sequence 0x0001..0x0005 unchanged.
3. Opsum count=2, `dst_opsum_ready` low for 6 cycles after the first valid.
   - `dst_opsum_data` is held stable.
   - No second pop until that word is accepted.
   - Second word value is correct.
4. All counts 0, then `start`.
   - No push or pop.
   - `done` 1 cycle after `start`; `busy` never rises.
5. `reset` asserted mid-run, on the cycle after a pop.
   - Next cycle: all outputs 0 and state IDLE.
   - A following `start` without `configure` gives `done` immediately.
6. With `PE_DRIVER_ABORT_EN`, `abort` 3 cycles into a run with ifmap=10.
   - Pushes stop the next cycle; `busy` = 0; no `done` pulse.

Source files
------------

// File: rtl/pe_driver_pkg.sv
// Package for the PE stream driver: run-state encoding and default widths.
package pe_driver_pkg;

  localparam int unsigned DEF_DATA_WIDTH_IFMAP  = 16;
  localparam int unsigned DEF_DATA_WIDTH_FILTER = 64;
  localparam int unsigned DEF_DATA_WIDTH_PSUM   = 64;
  localparam int unsigned DEF_COUNT_WIDTH       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pe_feed_channel.sv
// One feed channel of the PE stream driver: holds the remaining-word counter
// and gates the valid/ready source handshake into the PE FIFO push port.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   clear            drop the remaining count (run aborted)
//   load/load_count  latch a new remaining count
//   run              driver is in RUN
//   src_*            valid/ready source side
//   data, push       PE FIFO write side (data passed straight through)
//   fifo_full        PE FIFO full flag
//   rem_zero         no words left to send
module pe_feed_channel
  import pe_driver_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_DATA_WIDTH_IFMAP,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_count,
  input  logic                   run,
  input  logic [WIDTH-1:0]       src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic [WIDTH-1:0]       data,
  output logic                   push,
  input  logic                   fifo_full,
  output logic                   rem_zero
);

  logic [COUNT_WIDTH-1:0] rem_q;

  always_comb begin
    rem_zero  = (rem_q == '0);
    src_ready = run & ~fifo_full & ~rem_zero;
    push      = src_ready & src_valid;
    data      = src_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rem_q <= '0;
    end else if (load) begin
      rem_q <= load_count;
    end else if (push) begin
      rem_q <= rem_q - COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pe_stream_driver.sv
// Upstream/downstream driver for one PE wrapper. Streams a programmed number
// of ifmap, filter and ipsum words from valid/ready sources into the PE FIFO
// push ports and drains a programmed number of opsum words from the PE pop
// port into a valid/ready sink; pulses done once every stream has completed.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   configure, *_count         latch per-stream word counts (IDLE only)
//   start, busy, done          run control / status
//   src_{ifmap,filter,ipsum}_* valid/ready sources
//   {ifmap,filter,ipsum}, push_*, *_fifo_full  PE FIFO write ports
//   opsum, pop_opsum, opsum_fifo_empty         PE FIFO read port
//   dst_opsum_*                valid/ready sink
//   abort                      only with PE_DRIVER_ABORT_EN: cancel a run
// Build option: define PE_DRIVER_ABORT_EN to add the abort input.
module pe_stream_driver
  import pe_driver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IFMAP  = DEF_DATA_WIDTH_IFMAP,
  parameter int unsigned DATA_WIDTH_FILTER = DEF_DATA_WIDTH_FILTER,
  parameter int unsigned DATA_WIDTH_PSUM   = DEF_DATA_WIDTH_PSUM,
  parameter int unsigned COUNT_WIDTH       = DEF_COUNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef PE_DRIVER_ABORT_EN
  input  logic                         abort,
`endif
  input  logic                         configure,
  input  logic [COUNT_WIDTH-1:0]       ifmap_count,
  input  logic [COUNT_WIDTH-1:0]       filter_count,
  input  logic [COUNT_WIDTH-1:0]       ipsum_count,
  input  logic [COUNT_WIDTH-1:0]       opsum_count,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic [DATA_WIDTH_IFMAP-1:0]  src_ifmap_data,
  input  logic                         src_ifmap_valid,
  output logic                         src_ifmap_ready,
  input  logic [DATA_WIDTH_FILTER-1:0] src_filter_data,
  input  logic                         src_filter_valid,
  output logic                         src_filter_ready,
  input  logic [DATA_WIDTH_PSUM-1:0]   src_ipsum_data,
  input  logic                         src_ipsum_valid,
  output logic                         src_ipsum_ready,
  output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
  output logic                         push_ifmap,
  input  logic                         ifmap_fifo_full,
  output logic [DATA_WIDTH_FILTER-1:0] filter,
  output logic                         push_filter,
  input  logic                         filter_fifo_full,
  output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
  output logic                         push_ipsum,
  input  logic                         ipsum_fifo_full,
  input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
  output logic                         pop_opsum,
  input  logic                         opsum_fifo_empty,
  output logic [DATA_WIDTH_PSUM-1:0]   dst_opsum_data,
  output logic                         dst_opsum_valid,
  input  logic                         dst_opsum_ready
);

  state_t                 state_q;
  logic                   run;
  logic                   load;
  logic                   abort_run;
  logic                   ifmap_zero;
  logic                   filter_zero;
  logic                   ipsum_zero;
  logic                   all_zero;
  logic                   complete;
  logic [COUNT_WIDTH-1:0] rem_opsum_q;
  logic                   pend_q;
  logic                   dst_valid_q;
  logic [DATA_WIDTH_PSUM-1:0] dst_data_q;

  always_comb begin
    run  = (state_q == RUN);
    load = configure & (state_q == IDLE);
  end

`ifdef PE_DRIVER_ABORT_EN
  always_comb abort_run = abort & (state_q == RUN);
`else
  always_comb abort_run = 1'b0;
`endif

  pe_feed_channel #(.WIDTH(DATA_WIDTH_IFMAP), .COUNT_WIDTH(COUNT_WIDTH)) u_ifmap (
    .clk(clk), .reset(reset), .clear(abort_run), .load(load), .load_count(ifmap_count),
    .run(run), .src_data(src_ifmap_data), .src_valid(src_ifmap_valid),
    .src_ready(src_ifmap_ready), .data(ifmap), .push(push_ifmap),
    .fifo_full(ifmap_fifo_full), .rem_zero(ifmap_zero)
  );

  pe_feed_channel #(.WIDTH(DATA_WIDTH_FILTER), .COUNT_WIDTH(COUNT_WIDTH)) u_filter (
    .clk(clk), .reset(reset), .clear(abort_run), .load(load), .load_count(filter_count),
    .run(run), .src_data(src_filter_data), .src_valid(src_filter_valid),
    .src_ready(src_filter_ready), .data(filter), .push(push_filter),
    .fifo_full(filter_fifo_full), .rem_zero(filter_zero)
  );

  pe_feed_channel #(.WIDTH(DATA_WIDTH_PSUM), .COUNT_WIDTH(COUNT_WIDTH)) u_ipsum (
    .clk(clk), .reset(reset), .clear(abort_run), .load(load), .load_count(ipsum_count),
    .run(run), .src_data(src_ipsum_data), .src_valid(src_ipsum_valid),
    .src_ready(src_ipsum_ready), .data(ipsum), .push(push_ipsum),
    .fifo_full(ipsum_fifo_full), .rem_zero(ipsum_zero)
  );

  // Only one pop in flight: the PE FIFO read is registered, so the word is
  // captured in the cycle after the pop (pend_q) and a new pop waits for that.
  always_comb begin
    pop_opsum = run & ~opsum_fifo_empty & (rem_opsum_q != '0) & ~pend_q &
                (~dst_valid_q | dst_opsum_ready);
    all_zero  = ifmap_zero & filter_zero & ipsum_zero & (rem_opsum_q == '0);
    complete  = all_zero & ~pend_q & (~dst_valid_q | dst_opsum_ready);
    busy            = (state_q == RUN);
    done            = (state_q == DONE);
    dst_opsum_valid = dst_valid_q;
    dst_opsum_data  = dst_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset || abort_run) begin
      rem_opsum_q <= '0;
      pend_q      <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
    end else begin
      pend_q <= pop_opsum;
      if (load) begin
        rem_opsum_q <= opsum_count;
      end else if (pend_q) begin
        rem_opsum_q <= rem_opsum_q - COUNT_WIDTH'(1);
      end
      if (pend_q) begin
        dst_data_q  <= opsum;
        dst_valid_q <= 1'b1;
      end else if (dst_opsum_ready) begin
        dst_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= all_zero ? DONE : RUN;
        end
        RUN: begin
          if (abort_run)     state_q <= IDLE;
          else if (complete) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_stream_driver.sv
module tb_pe_stream_driver;

  localparam logic [15:0] IF_BASE = 16'h0001;
  localparam logic [63:0] FL_BASE = 64'hF000_0000_0000_0100;
  localparam logic [63:0] IP_BASE = 64'h1500_0000_0000_0200;
  localparam logic [63:0] OP_BASE = 64'h0B5E_0000_0000_0300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
`ifdef PE_DRIVER_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        configure = 1'b0;
  logic [15:0] ifmap_count = '0, filter_count = '0, ipsum_count = '0, opsum_count = '0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [15:0] src_ifmap_data;
  logic [63:0] src_filter_data, src_ipsum_data;
  logic        src_ifmap_valid = 1'b1, src_filter_valid = 1'b1, src_ipsum_valid = 1'b1;
  logic        src_ifmap_ready, src_filter_ready, src_ipsum_ready;
  logic [15:0] ifmap;
  logic [63:0] filter, ipsum;
  logic        push_ifmap, push_filter, push_ipsum;
  logic        ifmap_fifo_full = 1'b0, filter_fifo_full = 1'b0, ipsum_fifo_full = 1'b0;
  logic [63:0] opsum;
  logic        pop_opsum;
  logic        opsum_fifo_empty = 1'b0;
  logic [63:0] dst_opsum_data;
  logic        dst_opsum_valid;
  logic        dst_opsum_ready = 1'b1;

  pe_stream_driver #(
    .DATA_WIDTH_IFMAP(16), .DATA_WIDTH_FILTER(64), .DATA_WIDTH_PSUM(64), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
`ifdef PE_DRIVER_ABORT_EN
    .abort(abort),
`endif
    .configure(configure), .ifmap_count(ifmap_count), .filter_count(filter_count),
    .ipsum_count(ipsum_count), .opsum_count(opsum_count), .start(start),
    .busy(busy), .done(done),
    .src_ifmap_data(src_ifmap_data), .src_ifmap_valid(src_ifmap_valid), .src_ifmap_ready(src_ifmap_ready),
    .src_filter_data(src_filter_data), .src_filter_valid(src_filter_valid), .src_filter_ready(src_filter_ready),
    .src_ipsum_data(src_ipsum_data), .src_ipsum_valid(src_ipsum_valid), .src_ipsum_ready(src_ipsum_ready),
    .ifmap(ifmap), .push_ifmap(push_ifmap), .ifmap_fifo_full(ifmap_fifo_full),
    .filter(filter), .push_filter(push_filter), .filter_fifo_full(filter_fifo_full),
    .ipsum(ipsum), .push_ipsum(push_ipsum), .ipsum_fifo_full(ipsum_fifo_full),
    .opsum(opsum), .pop_opsum(pop_opsum), .opsum_fifo_empty(opsum_fifo_empty),
    .dst_opsum_data(dst_opsum_data), .dst_opsum_valid(dst_opsum_valid), .dst_opsum_ready(dst_opsum_ready)
  );

  always #5 clk = ~clk;

  // Sources advance to the next word on each accepted push.
  always @(posedge clk) begin
    if (reset) begin
      src_ifmap_data  <= IF_BASE;
      src_filter_data <= FL_BASE;
      src_ipsum_data  <= IP_BASE;
    end else begin
      if (push_ifmap)  src_ifmap_data  <= src_ifmap_data + 16'd1;
      if (push_filter) src_filter_data <= src_filter_data + 64'd1;
      if (push_ipsum)  src_ipsum_data  <= src_ipsum_data + 64'd1;
    end
  end

  // PE output FIFO with registered read: word appears the cycle after pop.
  int unsigned pop_idx;
  always @(posedge clk) begin
    if (reset) begin
      pop_idx <= 0;
      opsum   <= '0;
    end else if (pop_opsum) begin
      opsum   <= OP_BASE + 64'(pop_idx);
      pop_idx <= pop_idx + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int unsigned if_cnt, fl_cnt, ip_cnt, pop_cnt, acc_cnt, busy_cnt, done_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor_step();
    if (reset) begin
      if_cnt = 0; fl_cnt = 0; ip_cnt = 0; pop_cnt = 0; acc_cnt = 0; busy_cnt = 0; done_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (push_ifmap) begin
        chk("ifmap_data", 64'(ifmap), 64'(IF_BASE + 16'(if_cnt)));
        chk("ifmap_push_while_full", 64'(ifmap_fifo_full), 64'd0);
        if_cnt++;
      end
      if (push_filter) begin
        chk("filter_data", filter, FL_BASE + 64'(fl_cnt));
        fl_cnt++;
      end
      if (push_ipsum) begin
        chk("ipsum_data", ipsum, IP_BASE + 64'(ip_cnt));
        ip_cnt++;
      end
      if (pop_opsum) pop_cnt++;
      if (dst_opsum_valid && dst_opsum_ready) begin
        chk("opsum_data", dst_opsum_data, OP_BASE + 64'(acc_cnt));
        acc_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic do_config(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    ifmap_count = a; filter_count = b; ipsum_count = c; opsum_count = d;
    configure = 1'b1;
    tick();
    configure = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(done_cnt != 0), 64'd1);
    repeat (3) tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_readies"}, 64'({src_ifmap_ready, src_filter_ready, src_ipsum_ready}), 64'd0);
    chk({name, "_pushes"}, 64'({push_ifmap, push_filter, push_ipsum}), 64'd0);
    chk({name, "_pop"}, 64'(pop_opsum), 64'd0);
    chk({name, "_dst_valid"}, 64'(dst_opsum_valid), 64'd0);
    chk({name, "_dst_data"}, dst_opsum_data, 64'd0);
  endtask

  typedef struct {
    logic [15:0] ifc, flc, ipc, opc;
    int unsigned exp_busy;
  } vec_t;

  vec_t vecs[5];
  logic [63:0] held;

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // counts -> expected busy cycles (all streams free-flowing)
    vecs[0] = '{16'd4, 16'd2, 16'd3, 16'd3, 7};
    vecs[1] = '{16'd1, 16'd1, 16'd1, 16'd0, 2};
    vecs[2] = '{16'd0, 16'd0, 16'd0, 16'd1, 3};
    vecs[3] = '{16'd6, 16'd0, 16'd2, 16'd2, 7};
    vecs[4] = '{16'd0, 16'd0, 16'd0, 16'd0, 0};

    do_reset();
    sample();
    chk_all_zero("reset");

    for (int i = 0; i < 5; i++) begin
      do_reset();
      do_config(vecs[i].ifc, vecs[i].flc, vecs[i].ipc, vecs[i].opc);
      start_run();
      wait_done("vec_done_timeout", 100);
      chk("vec_ifmap_pushes", 64'(if_cnt), 64'(vecs[i].ifc));
      chk("vec_filter_pushes", 64'(fl_cnt), 64'(vecs[i].flc));
      chk("vec_ipsum_pushes", 64'(ip_cnt), 64'(vecs[i].ipc));
      chk("vec_opsum_pops", 64'(pop_cnt), 64'(vecs[i].opc));
      chk("vec_opsum_accepts", 64'(acc_cnt), 64'(vecs[i].opc));
      chk("vec_busy_cycles", 64'(busy_cnt), 64'(vecs[i].exp_busy));
      chk("vec_done_pulses", 64'(done_cnt), 64'd1);
    end

    // ifmap FIFO full during run cycles 2..4
    do_reset();
    do_config(16'd5, 16'd0, 16'd0, 16'd0);
    start_run();
    tick();
    tick();
    ifmap_fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("full_no_push", 64'(push_ifmap), 64'd0);
      tick();
    end
    ifmap_fifo_full = 1'b0;
    wait_done("full_done_timeout", 50);
    chk("full_pushes", 64'(if_cnt), 64'd5);
    chk("full_busy_cycles", 64'(busy_cnt), 64'd9);

    // sink back-pressure on the first opsum word
    do_reset();
    dst_opsum_ready = 1'b0;
    do_config(16'd0, 16'd0, 16'd0, 16'd2);
    start_run();
    begin
      int n = 0;
      sample();
      while (!dst_opsum_valid && n < 10) begin
        sample();
        n++;
      end
    end
    chk("bp_valid_seen", 64'(dst_opsum_valid), 64'd1);
    held = dst_opsum_data;
    chk("bp_first_word", held, OP_BASE);
    for (int k = 0; k < 6; k++) begin
      tick();
      sample();
      chk("bp_valid_held", 64'(dst_opsum_valid), 64'd1);
      chk("bp_data_stable", dst_opsum_data, held);
      chk("bp_no_pop", 64'(pop_opsum), 64'd0);
    end
    chk("bp_single_pop", 64'(pop_cnt), 64'd1);
    tick();
    dst_opsum_ready = 1'b1;
    wait_done("bp_done_timeout", 50);
    chk("bp_pops", 64'(pop_cnt), 64'd2);
    chk("bp_accepts", 64'(acc_cnt), 64'd2);

    // all counts zero: immediate done, never busy
    do_reset();
    do_config(16'd0, 16'd0, 16'd0, 16'd0);
    start_run();
    sample();
    chk("zero_done_next", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    tick();
    sample();
    chk("zero_done_one_cycle", 64'(done), 64'd0);
    chk("zero_no_push", 64'(if_cnt + fl_cnt + ip_cnt + pop_cnt), 64'd0);

    // reset in the cycle after a pop
    do_reset();
    do_config(16'd3, 16'd0, 16'd0, 16'd2);
    start_run();
    sample();
    chk("rst_pop_cycle0", 64'(pop_opsum), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    chk_all_zero("midrun_reset");
    tick();
    start_run();
    sample();
    chk("rst_restart_done", 64'(done), 64'd1);
    repeat (3) tick();
    chk("rst_word_discarded", 64'(acc_cnt), 64'd0);

`ifdef PE_DRIVER_ABORT_EN
    do_reset();
    do_config(16'd10, 16'd0, 16'd0, 16'd0);
    start_run();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sample();
    chk("abort_no_push", 64'(push_ifmap), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (4) tick();
    chk("abort_pushes", 64'(if_cnt), 64'd3);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    start_run();
    sample();
    chk("abort_counters_cleared", 64'(done), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
